givens_feed_sched: RTL
======================

// Module: givens_feed_sched
// PURPOSE
//  Sequencer for the linear Givens-rotation systolic array (N columns of PE cells).
//  Accepts matrix rows over a valid/ready handshake and applies the diagonal input skew:
//  element j of a row is delayed by j cycles. Clears the array between jobs and signals
//  completion once the last row has drained through the skew network.
// PARAMETERS
//  N      4    array width: columns per row, one skew lane per column (N>=2)
//  M_MAX  16   maximum rows per job; counter width CW = $clog2(M_MAX+1)
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin job; sampled only in IDLE
//  rows_cfg   in   CW       rows in job, captured with start; legal 1..M_MAX
//  abort      in   1        cancel running job
//  in_valid   in   1        in_row holds a row
//  in_ready   out  1        scheduler accepts in_row this cycle
//  in_row     in   real[N]  row elements, index 0 = leftmost column
//  col_x      out  real[N]  skewed element to column j's x_in
//  col_vld    out  N        col_x[j] carries real data (0 = bubble)
//  pe_clr     out  1        drives the array rst; clears every PE state register
//  busy       out  1        high in every state except IDLE
//  done       out  1        one-cycle pulse when a job completes normally
// BEHAVIOUR
//  Reset: state IDLE; col_x all 0.0; col_vld, in_ready, done, busy = 0; pe_clr = 1 on the
//   reset cycle(s) and 0 the cycle after rst deasserts; skew lanes flushed; counters 0.
//  States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE:  start && rows_cfg in 1..M_MAX: capture rows_cfg, go CLEAR. rows_cfg==0 or
//   >M_MAX: start ignored, stay IDLE. start outside IDLE ignored.
//  CLEAR: exactly one cycle; pe_clr=1, skew lanes flushed to 0.0/invalid; next FEED.
//  FEED:  in_ready=1 (combinational from state). Accept = in_valid && in_ready.
//   Lane j is a j+1-stage register chain; on accept stage 0 loads in_row[j], valid=1;
//   with no accept stage 0 loads 0.0, valid=0 (bubble). Row accepted at cycle a appears
//   as col_x[j]/col_vld[j] at cycle a+1+j. Bubbles keep the same skew alignment.
//   row_cnt increments per accept; accept with row_cnt==rows_cfg-1 -> DRAIN.
//  DRAIN: in_ready=0, lanes shift bubbles in; counter runs N cycles so the last row's
//   column N-1 element is presented; then DONE.
//  DONE:  done=1 for one cycle, busy still 1; next IDLE. col_vld all 0 by this cycle.
//  abort (FEED or DRAIN): next cycle IDLE, lanes flushed, pe_clr=1 for that one cycle,
//   done not asserted. abort in IDLE/CLEAR/DONE ignored. rst overrides abort and start.
//  Data path passes reals unmodified; no arithmetic on data. Counters never wrap: row_cnt
//   bounded by rows_cfg, drain counter by N.
//  in_valid held high in DRAIN/IDLE is not consumed; in_row may change freely when
//   in_ready=0.
// TESTING
//  N=4, rows_cfg=3, in_valid always 1, rows R0..R2 -> R0[j] on col_x[j] at cycle a0+1+j,
//   in_ready drops after 3 accepts, done pulses exactly once, busy low next cycle.
//  rows_cfg=3 with in_valid gaps (1,0,1,0,1) -> col_vld shows matching bubbles per lane,
//   column skew preserved, no row lost or duplicated.
//  start with rows_cfg=0 and rows_cfg=17 (M_MAX=16) -> stays IDLE, busy=0, pe_clr=0.
//  abort after 2nd accepted row of 4 -> next cycle IDLE, pe_clr=1 one cycle, no done;
//   new start afterwards completes normally with only new-job data on col_x.
//  rst asserted in DRAIN -> all outputs at reset values next cycle, pe_clr=1 while rst
//   high; start re-issued after release completes normally.
//  Back-to-back jobs: start asserted in the cycle after done -> CLEAR pulse precedes
//   any valid data of job 2; no job-1 element ever appears with col_vld=1 after CLEAR.

Source files
------------

// File: rtl/givens_feed_sched.sv
// -----------------------------------------------------------------------------
// givens_feed_sched
//   Input sequencer for a linear Givens-rotation systolic array of N columns.
//   Rows arrive over a valid/ready handshake. Each element is delayed by its
//   column index so that the array sees the diagonal wavefront it expects.
//   The array is cleared before every job. Completion is flagged once the
//   last row has fully drained out of the skew lanes.
//
// Ports
//   clk       : clock; all logic is on the rising edge
//   rst       : synchronous, active-high reset
//   start     : begin a job (only honoured in IDLE)
//   rows_cfg  : rows in the job, captured with start; legal range 1..M_MAX
//   abort     : cancel the running job (FEED/DRAIN only)
//   in_valid  : in_row holds a row
//   in_ready  : a row is accepted this cycle when in_valid is also high
//   in_row    : row elements, index 0 = leftmost column
//   col_x     : skewed element presented to column j
//   col_vld   : col_x[j] carries real data (0 = bubble)
//   pe_clr    : clears every PE state register in the array
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse on normal job completion
// -----------------------------------------------------------------------------
module givens_feed_sched #(
  parameter  int N     = 4,
  parameter  int M_MAX = 16,
  localparam int CW    = $clog2(M_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] rows_cfg,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  real           in_row [N],
  output real           col_x  [N],
  output logic [N-1:0]  col_vld,
  output logic          pe_clr,
  output logic          busy,
  output logic          done
);

  localparam int DW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rows_q, rows_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          abort_clr_q, abort_clr_d;
  logic          abort_take;
  logic          accept;
  logic          flush;

  assign in_ready = (state_q == S_FEED);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  // The array is held clear during reset, in CLEAR, and in the cycle after an abort.
  assign pe_clr   = rst || (state_q == S_CLEAR) || abort_clr_q;
  // Lanes empty at the end of CLEAR and on the abort edge, so no stale element
  // of a cancelled job can reach the array afterwards.
  assign flush    = (state_q == S_CLEAR) || abort_take;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    abort_clr_d = 1'b0;
    abort_take  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (rows_cfg != '0) && (rows_cfg <= CW'(M_MAX))) begin
          rows_d  = rows_cfg;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        row_cnt_d   = '0;
        drain_cnt_d = '0;
        state_d     = S_FEED;
      end
      S_FEED: begin
        if (abort) begin
          abort_take  = 1'b1;
          abort_clr_d = 1'b1;
          state_d     = S_IDLE;
        end else if (accept) begin
          row_cnt_d = row_cnt_q + CW'(1);
          if (row_cnt_q == rows_q - CW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          abort_take  = 1'b1;
          abort_clr_d = 1'b1;
          state_d     = S_IDLE;
        end else if (drain_cnt_q == DW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  // Lane j is a (j+1)-stage chain: a row accepted in cycle a shows element j
  // on col_x[j] in cycle a+1+j. Idle cycles shift bubbles with the same skew.
  for (genvar j = 0; j < N; j++) begin : g_lane
    real  x_q [0:j];
    logic v_q [0:j];

    // NOTE: the skew stages are ordinary registers that must be empty after
    // reset (no phantom valids), so they are reset, unlike RAM-style storage.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int k = 0; k <= j; k++) begin
          x_q[k] <= 0.0;
          v_q[k] <= 1'b0;
        end
      end else begin
        x_q[0] <= accept ? in_row[j] : 0.0;
        v_q[0] <= accept;
        for (int k = 1; k <= j; k++) begin
          x_q[k] <= x_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign col_x[j]   = x_q[j];
    assign col_vld[j] = v_q[j];
  end

endmodule
